// File: rtl/vx_launch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vx_launch_pkg
//  Description : Shared constants for the Vortex launch sequencer: FSM state
//                encoding, APB register offsets and STATUS field positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package vx_launch_pkg;

   // FSM state encoding (3 bits wide so it drops straight into STATUS[6:4])
   typedef logic [2:0] vx_state_t;
   localparam vx_state_t c_ST_IDLE  = 3'd0;
   localparam vx_state_t c_ST_RESET = 3'd1;
   localparam vx_state_t c_ST_RUN   = 3'd2;
   localparam vx_state_t c_ST_DONE  = 3'd3;

   // APB register offsets (only paddr[7:0] is decoded)
   localparam logic [7:0] c_OFF_MEM_BASE = 8'h50;
   localparam logic [7:0] c_OFF_CTRL     = 8'h54;
   localparam logic [7:0] c_OFF_STATUS   = 8'h58;
   localparam logic [7:0] c_OFF_CYCLES   = 8'h5C;
   localparam logic [7:0] c_OFF_TIMEOUT  = 8'h60;

   // CTRL bit positions
   localparam int c_CTRL_START = 0;
   localparam int c_CTRL_ABORT = 1;

   // STATUS bit positions
   localparam int c_STAT_BUSY     = 0;
   localparam int c_STAT_DONE     = 1;
   localparam int c_STAT_TIMEOUT  = 2;
   localparam int c_STAT_STATE_LO = 4;

   // Assemble the STATUS read word from its fields
   function automatic logic [31:0] status_word(input logic      busy_sync,
                                                input logic      done,
                                                input logic      timeout,
                                                input vx_state_t state);
      logic [31:0] w;
      w                            = '0;
      w[c_STAT_BUSY]               = busy_sync;
      w[c_STAT_DONE]               = done;
      w[c_STAT_TIMEOUT]            = timeout;
      w[c_STAT_STATE_LO +: 3]      = state;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vx_apb_regs.sv
`default_nettype none
// ============================================================================
//  Module      : vx_apb_regs
//  Description : APB slave for the launch sequencer. Decodes offsets, stores
//                MEM_BASE and TIMEOUT, produces command/clear pulses for the
//                FSM and the registered prdata / pslverr responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module vx_apb_regs
   import vx_launch_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_psel,
   input  logic             i_penable,
   input  logic             i_pwrite,
   input  logic [7:0]       i_paddr,
   input  logic [31:0]      i_pwdata,
   output logic [31:0]      o_prdata,
   output logic             o_pslverr,
   input  vx_state_t        i_state,
   input  logic             i_busy_sync,
   input  logic             i_done,
   input  logic             i_timeout,
   input  logic [CNT_W-1:0] i_cycles,
   output logic [31:0]      o_mem_base,
   output logic [CNT_W-1:0] o_timeout_lim,
   output logic             o_start,
   output logic             o_abort,
   output logic             o_clr_done,
   output logic             o_clr_timeout
);

   logic             w_wr;
   logic             w_setup_rd;
   logic             w_mapped;
   logic             w_idle;
   logic [31:0]      w_rdata;
   logic [31:0]      r_prdata;
   logic             r_pslverr;
   logic [31:0]      r_mem_base;
   logic [CNT_W-1:0] r_timeout_lim;

   assign w_wr       = i_psel & i_penable & i_pwrite;
   assign w_setup_rd = i_psel & ~i_penable & ~i_pwrite;
   assign w_idle     = (i_state == c_ST_IDLE);

   // Offset decode and read-data mux
   always_comb begin
      w_mapped = 1'b1;
      w_rdata  = '0;
      case (i_paddr)
         c_OFF_MEM_BASE: w_rdata = r_mem_base;
         c_OFF_CTRL:     w_rdata = '0;
         c_OFF_STATUS:   w_rdata = status_word(i_busy_sync, i_done, i_timeout, i_state);
         c_OFF_CYCLES:   w_rdata = 32'(i_cycles);
         c_OFF_TIMEOUT:  w_rdata = 32'(r_timeout_lim);
         default:        w_mapped = 1'b0;
      endcase
   end

   // Single-cycle command and clear strobes, valid on the write commit edge
   assign o_start       = w_wr & (i_paddr == c_OFF_CTRL)   & i_pwdata[c_CTRL_START];
   assign o_abort       = w_wr & (i_paddr == c_OFF_CTRL)   & i_pwdata[c_CTRL_ABORT];
   assign o_clr_done    = w_wr & (i_paddr == c_OFF_STATUS) & i_pwdata[c_STAT_DONE];
   assign o_clr_timeout = w_wr & (i_paddr == c_OFF_STATUS) & i_pwdata[c_STAT_TIMEOUT];

   // Response path: both prdata and pslverr are captured in the setup phase so
   // they are stable for the whole access phase; pslverr drops on the next edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prdata  <= '0;
         r_pslverr <= 1'b0;
      end else begin
         if (w_setup_rd) begin
            r_prdata <= w_rdata;
         end
         r_pslverr <= i_psel & ~i_penable & ~w_mapped;
      end
   end

   // Configuration storage; frozen while a launch is in progress
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mem_base    <= '0;
         r_timeout_lim <= '0;
      end else if (w_wr && w_idle) begin
         if (i_paddr == c_OFF_MEM_BASE) begin
            r_mem_base <= i_pwdata;
         end
         if (i_paddr == c_OFF_TIMEOUT) begin
            r_timeout_lim <= CNT_W'(i_pwdata);
         end
      end
   end

   assign o_prdata      = r_prdata;
   assign o_pslverr     = r_pslverr;
   assign o_mem_base    = r_mem_base;
   assign o_timeout_lim = r_timeout_lim;

endmodule
`default_nettype wire

// File: rtl/vx_launch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vx_launch_ctrl
//  Description : APB-programmed launch sequencer for a Vortex AXI instance.
//                Holds the memory base offset, drives core reset and clock
//                enable, and runs one kernel: reset -> run -> done/timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module vx_launch_ctrl
   import vx_launch_pkg::*;
#(
   parameter int RESET_DELAY = 8,
   parameter int IDLE_FILTER = 4,
   parameter int CNT_W       = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   input  logic        vx_busy,
   output logic        vx_reset,
   output logic        vx_clk_en,
   output logic [31:0] mem_base,
   output logic        irq
);

   localparam int c_RST_W  = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;
   localparam int c_IDLE_W = (IDLE_FILTER > 1) ? $clog2(IDLE_FILTER) : 1;
   localparam logic [c_RST_W-1:0]  c_RST_LAST  = c_RST_W'(RESET_DELAY - 1);
   localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(IDLE_FILTER - 1);

   vx_state_t         r_state;
   vx_state_t         w_state_nxt;
   logic              r_busy_meta;
   logic              r_busy_sync;
   logic              r_done;
   logic              r_timeout;
   logic              w_done_nxt;
   logic              w_timeout_nxt;
   logic              r_irq;
   logic              r_vx_reset;
   logic              r_vx_clk_en;
   logic [c_RST_W-1:0]  r_rst_ctr;
   logic [c_IDLE_W-1:0] r_idle_ctr;
   logic [CNT_W-1:0]  r_cycles;
   logic [CNT_W-1:0]  w_timeout_lim;
   logic              w_start;
   logic              w_abort;
   logic              w_clr_done;
   logic              w_clr_timeout;
   logic              w_launch;
   logic              w_run_idle;
   logic              w_run_expire;
   logic              w_unused_addr;

   assign w_unused_addr = &{1'b0, paddr[31:8]};

   vx_apb_regs #(
      .CNT_W (CNT_W)
   ) u_regs (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_psel        (psel),
      .i_penable     (penable),
      .i_pwrite      (pwrite),
      .i_paddr       (paddr[7:0]),
      .i_pwdata      (pwdata),
      .o_prdata      (prdata),
      .o_pslverr     (pslverr),
      .i_state       (r_state),
      .i_busy_sync   (r_busy_sync),
      .i_done        (r_done),
      .i_timeout     (r_timeout),
      .i_cycles      (r_cycles),
      .o_mem_base    (mem_base),
      .o_timeout_lim (w_timeout_lim),
      .o_start       (w_start),
      .o_abort       (w_abort),
      .o_clr_done    (w_clr_done),
      .o_clr_timeout (w_clr_timeout)
   );

   // Two-flop synchronizer for the core busy flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_busy_meta <= 1'b0;
         r_busy_sync <= 1'b0;
      end else begin
         r_busy_meta <= vx_busy;
         r_busy_sync <= r_busy_meta;
      end
   end

   assign w_launch     = (r_state == c_ST_IDLE) && w_start && !w_abort;
   assign w_run_idle   = (r_idle_ctr == c_IDLE_LAST) && !r_busy_sync;
   assign w_run_expire = (w_timeout_lim != '0) && (r_cycles == (w_timeout_lim - CNT_W'(1)));

   // Next-state and flag logic; ABORT overrides everything and sets no flags.
   // done marks any finished run, timeout qualifies it as watchdog-ended.
   always_comb begin
      w_state_nxt   = r_state;
      w_done_nxt    = r_done & ~w_clr_done;
      w_timeout_nxt = r_timeout & ~w_clr_timeout;
      if (w_abort) begin
         w_state_nxt = c_ST_IDLE;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (w_start) begin
                  w_state_nxt   = c_ST_RESET;
                  w_done_nxt    = 1'b0;
                  w_timeout_nxt = 1'b0;
               end
            end
            c_ST_RESET: begin
               if (r_rst_ctr == c_RST_LAST) begin
                  w_state_nxt = c_ST_RUN;
               end
            end
            c_ST_RUN: begin
               if (w_run_idle || w_run_expire) begin
                  w_state_nxt = c_ST_DONE;
                  w_done_nxt  = 1'b1;
                  if (w_run_expire) begin
                     w_timeout_nxt = 1'b1;
                  end
               end
            end
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
         endcase
      end
   end

   // State, flags and the outputs derived from the next state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= c_ST_IDLE;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
         r_irq       <= 1'b0;
         r_vx_reset  <= 1'b1;
         r_vx_clk_en <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_done      <= w_done_nxt;
         r_timeout   <= w_timeout_nxt;
         r_irq       <= w_done_nxt | w_timeout_nxt;
         r_vx_reset  <= (w_state_nxt == c_ST_IDLE) || (w_state_nxt == c_ST_RESET);
         r_vx_clk_en <= (w_state_nxt == c_ST_RESET) || (w_state_nxt == c_ST_RUN);
      end
   end

   // Reset-delay, idle-filter and run-cycle counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rst_ctr  <= '0;
         r_idle_ctr <= '0;
         r_cycles   <= '0;
      end else if (w_launch) begin
         r_rst_ctr  <= '0;
         r_idle_ctr <= '0;
         r_cycles   <= '0;
      end else begin
         if (r_state == c_ST_RESET) begin
            r_rst_ctr <= r_rst_ctr + c_RST_W'(1);
         end
         if (r_state == c_ST_RUN) begin
            if (r_cycles != '1) begin
               r_cycles <= r_cycles + CNT_W'(1);
            end
            if (r_busy_sync) begin
               r_idle_ctr <= '0;
            end else begin
               r_idle_ctr <= r_idle_ctr + c_IDLE_W'(1);
            end
         end
      end
   end

   assign pready    = 1'b1;
   assign vx_reset  = r_vx_reset;
   assign vx_clk_en = r_vx_clk_en;
   assign irq       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_vx_launch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vx_launch_ctrl
//  Description : Self-checking bench for vx_launch_ctrl: register vector table,
//                directed launch scenarios and randomized busy patterns
//                checked against a run-length reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_launch_ctrl;

   localparam int D    = 8;
   localparam int F    = 4;
   localparam int PMAX = 256;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic        vx_busy;
   logic        vx_reset, vx_clk_en;
   logic [31:0] mem_base;
   logic        irq;

   int n_chk  = 0;
   int n_pass = 0;

   // Busy value the core presents, indexed by RUN cycle number (1-based)
   bit pat [1:PMAX];

   vx_launch_ctrl #(.RESET_DELAY(D), .IDLE_FILTER(F), .CNT_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .psel(psel), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
      .pready(pready), .pslverr(pslverr), .vx_busy(vx_busy),
      .vx_reset(vx_reset), .vx_clk_en(vx_clk_en), .mem_base(mem_base), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
   endtask

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(negedge clk);
      penable = 1'b1;
      #1 err = pslverr;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      @(negedge clk);
      penable = 1'b1;
      #1 begin d = prdata; err = pslverr; end
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
   endtask

   // Reference: the run ends at the first RUN cycle n where the synchronized busy
   // has been low for F consecutive RUN cycles, or n equals a nonzero limit.
   function automatic void model(input int t_lim, output int n_end, output bit e_to);
      int zrun;
      zrun  = 0;
      n_end = PMAX;
      e_to  = 1'b0;
      for (int n = 1; n <= PMAX; n++) begin
         zrun = pat[n] ? 0 : zrun + 1;
         if (zrun >= F || (t_lim != 0 && n == t_lim)) begin
            n_end = n;
            e_to  = (t_lim != 0 && n == t_lim);
            break;
         end
      end
   endfunction

   // Launch one kernel, follow it cycle by cycle, then read STATUS and CYCLES
   task automatic run_job(input string tag, input int t_lim);
      int          n_end, n, k;
      bit          e_to;
      logic        er, ee, ei, err;
      logic [31:0] rd;
      model(t_lim, n_end, e_to);
      vx_busy = 1'b1;
      apb_write(32'h60, t_lim, err);
      apb_write(32'h54, 32'h1, err);
      // Now just after the START commit edge; busy driven here is sampled on
      // the next edge and seen by the FSM two edges after that.
      for (int m = 1; m <= D + n_end + 2; m++) begin
         k = m - 1;
         if (k < D)               begin er = 1; ee = 1; ei = 0; end
         else if (k < D + n_end)  begin er = 0; ee = 1; ei = 0; end
         else if (k == D + n_end) begin er = 0; ee = 0; ei = 1; end
         else                     begin er = 1; ee = 0; ei = 1; end
         check($sformatf("%s cyc%0d rst/en/irq", tag, k), {29'b0, vx_reset, vx_clk_en, irq},
               {29'b0, er, ee, ei});
         n = m - D + 2;
         vx_busy = (n >= 1 && n <= PMAX) ? pat[n] : 1'b1;
         @(negedge clk);
      end
      vx_busy = 1'b0;
      repeat (2) @(negedge clk);
      apb_read(32'h58, rd, err);
      check({tag, " STATUS"}, rd, {29'b0, e_to, 1'b1, 1'b0});
      apb_read(32'h5C, rd, err);
      check({tag, " CYCLES"}, rd, n_end);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      bit          chk_rd;
      bit          exp_err;
   } vec_t;

   vec_t        tbl [16];
   logic [31:0] rd;
   logic        err;
   int          h, tl;

   initial begin
      // Register access vectors: {wr, addr, wdata, exp_rd, chk_rd, exp_err}
      tbl[0]  = '{1'b0, 32'h50,        32'h0,         32'h0,         1'b1, 1'b0};
      tbl[1]  = '{1'b0, 32'h58,        32'h0,         32'h0,         1'b1, 1'b0};
      tbl[2]  = '{1'b0, 32'h5C,        32'h0,         32'h0,         1'b1, 1'b0};
      tbl[3]  = '{1'b0, 32'h60,        32'h0,         32'h0,         1'b1, 1'b0};
      tbl[4]  = '{1'b1, 32'h50,        32'h8000_0000, 32'h0,         1'b0, 1'b0};
      tbl[5]  = '{1'b0, 32'h50,        32'h0,         32'h8000_0000, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 32'h60,        32'h0000_1234, 32'h0,         1'b0, 1'b0};
      tbl[7]  = '{1'b0, 32'h1000_0060, 32'h0,         32'h0000_1234, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 32'h60,        32'h0,         32'h0,         1'b0, 1'b0};
      tbl[9]  = '{1'b0, 32'h54,        32'h0,         32'h0,         1'b1, 1'b0};
      tbl[10] = '{1'b0, 32'h70,        32'h0,         32'h0,         1'b0, 1'b1};
      tbl[11] = '{1'b1, 32'h70,        32'h1,         32'h0,         1'b0, 1'b1};
      tbl[12] = '{1'b0, 32'h4C,        32'h0,         32'h0,         1'b0, 1'b1};
      tbl[13] = '{1'b0, 32'h64,        32'h0,         32'h0,         1'b0, 1'b1};
      tbl[14] = '{1'b1, 32'h5C,        32'h5,         32'h0,         1'b0, 1'b0};
      tbl[15] = '{1'b0, 32'h5C,        32'h0,         32'h0,         1'b1, 1'b0};

      reset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; vx_busy = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // 1. reset state
      check("rst vx_reset/clk_en/irq", {29'b0, vx_reset, vx_clk_en, irq}, 32'h4);
      check("rst mem_base", mem_base, 32'h0);
      check("rst prdata/pslverr/pready", {prdata[30:0], pslverr, pready}, 32'h1);

      for (int i = 0; i < 16; i++) begin
         if (tbl[i].wr) apb_write(tbl[i].addr, tbl[i].wdata, err);
         else           apb_read(tbl[i].addr, rd, err);
         check($sformatf("vec%0d pslverr", i), {31'b0, err}, {31'b0, tbl[i].exp_err});
         if (tbl[i].chk_rd) check($sformatf("vec%0d prdata", i), rd, tbl[i].exp_rd);
      end
      check("mem_base port", mem_base, 32'h8000_0000);

      // 2. busy high 100 RUN cycles then low: completion after the filter
      for (int n = 1; n <= PMAX; n++) pat[n] = (n <= 100);
      run_job("busy100", 0);

      // 3. watchdog at 50 cycles with busy stuck high, then W1C
      for (int n = 1; n <= PMAX; n++) pat[n] = 1'b1;
      run_job("tmo50", 50);
      check("tmo irq", {31'b0, irq}, 32'h1);
      apb_write(32'h58, 32'h4, err);
      apb_read(32'h58, rd, err);
      check("w1c timeout only", rd, 32'h2);
      check("w1c partial irq", {31'b0, irq}, 32'h1);
      apb_write(32'h58, 32'h2, err);
      check("w1c all irq", {31'b0, irq}, 32'h0);
      apb_read(32'h58, rd, err);
      check("w1c status", rd, 32'h0);

      // 4. two-cycle busy glitch shorter than the filter
      for (int n = 1; n <= PMAX; n++) pat[n] = !((n == 31) || (n == 32) || (n > 62));
      run_job("glitch", 0);

      // 5. ABORT mid-RUN; config writes ignored while running
      vx_busy = 1'b1;
      apb_write(32'h54, 32'h1, err);
      repeat (D + 10) @(negedge clk);
      check("abort pre run", {30'b0, vx_reset, vx_clk_en}, 32'h1);
      apb_read(32'h58, rd, err);
      check("status in RUN", rd, 32'h21);
      apb_write(32'h50, 32'h0000_1234, err);
      apb_write(32'h60, 32'h0000_0007, err);
      check("mem_base locked", mem_base, 32'h8000_0000);
      apb_write(32'h54, 32'h3, err);
      check("abort outputs", {29'b0, vx_reset, vx_clk_en, irq}, 32'h4);
      vx_busy = 1'b0;
      repeat (2) @(negedge clk);
      apb_read(32'h58, rd, err);
      check("abort status", rd, 32'h0);
      apb_read(32'h60, rd, err);
      check("timeout locked", rd, 32'h0);

      // Randomized runs against the model
      for (int r = 0; r < 12; r++) begin
         h  = $urandom_range(1, 60);
         tl = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(5, 80);
         for (int n = 1; n <= PMAX; n++) pat[n] = (n <= h) ? ($urandom_range(0, 3) != 0) : 1'b0;
         run_job($sformatf("rnd%0d", r), tl);
      end

      // 6. unmapped read error, then asynchronous reset in the middle of RESET
      apb_read(32'h70, rd, err);
      check("unmapped 0x70", {31'b0, err}, 32'h1);
      apb_read(32'h50, rd, err);
      check("mem_base before areset", rd, 32'h8000_0000);
      vx_busy = 1'b1;
      apb_write(32'h54, 32'h1, err);
      repeat (3) @(negedge clk);
      check("in RESET", {30'b0, vx_reset, vx_clk_en}, 32'h3);
      #2 reset_n = 1'b0;
      #1;
      check("areset rst/en/irq", {29'b0, vx_reset, vx_clk_en, irq}, 32'h4);
      check("areset mem_base", mem_base, 32'h0);
      check("areset prdata", prdata, 32'h0);
      check("areset pslverr", {31'b0, pslverr}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      vx_busy = 1'b0;
      repeat (2) @(negedge clk);
      apb_read(32'h58, rd, err);
      check("post areset status", rd, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vx_launch_ctrl.md
Name: vx_launch_ctrl

Overview:
APB-programmed launch sequencer for a Vortex_axi instance.
- Holds the memory base offset and drives the core's reset and clock-enable.
- Sequences one kernel run: start → multicycle reset → run → completion or timeout → interrupt.
- Sits between the APB configuration bus and the Vortex AXI wrapper. It replaces ad-hoc start/reset logic with an explicit FSM, a cycle counter and a watchdog.

Parameters:
RESET_DELAY, 8, cycles vx_reset is held high after start (≥1)
IDLE_FILTER, 4, consecutive vx_busy-low cycles required to declare completion (≥1)
CNT_W, 32, width of cycle counter and timeout register

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  32  APB address (bits [7:0] decoded)
pwdata  in  32  APB write data
prdata  out  32  APB read data
pready  out  1  APB ready, tied 1
pslverr  out  1  APB error for unmapped offset
vx_busy  in  1  busy from Vortex core
vx_reset  out  1  active-high reset to core
vx_clk_en  out  1  clock enable for core clock gate
mem_base  out  32  base offset added to core AXI addresses
irq  out  1  level interrupt, done or timeout

Behaviour:
- Reset: asynchronous, active-low; all registers clear on reset_n low, independent of clk.
  - Reset values: prdata=0, pslverr=0, vx_reset=1, vx_clk_en=0, mem_base=0, irq=0, state=IDLE, counters=0, timeout_lim=0.
- APB access:
  - Write: commits on psel&penable&pwrite.
  - Read: prdata is registered, loaded in the setup phase (psel&~penable&~pwrite), so it is valid in the access phase; otherwise prdata holds its value.
  - pslverr=psel&penable for an unmapped offset, else 0. Zero wait states.
- Register map:
  - 0x50 MEM_BASE (rw). Write ignored when state≠IDLE.
  - 0x54 CTRL (wo, reads 0). bit0 START: honoured only in IDLE. bit1 ABORT: honoured in any state.
  - 0x58 STATUS (rw1c). Fields: [0] busy_sync, [1] done, [2] timeout, [6:4] state. Write 1 to bit1 or bit2 to clear it; irq = done|timeout.
  - 0x5C CYCLES (ro). Cycles spent in RUN.
  - 0x60 TIMEOUT (rw). 0 = watchdog disabled. Write ignored when state≠IDLE.
- vx_busy passes through a 2-flop synchronizer (busy_sync) before any use.
- FSM states:
  - IDLE (0): vx_reset=1, vx_clk_en=0.
    - START → RESET. Clears done, timeout and CYCLES; loads rst_ctr=0.
    - START while done or timeout is still set is accepted and clears both flags.
  - RESET (1): vx_reset=1, vx_clk_en=1, rst_ctr increments each cycle.
    - When rst_ctr==RESET_DELAY-1 → RUN. vx_reset is therefore high for exactly RESET_DELAY cycles with the clock enabled.
  - RUN (2): vx_reset=0, vx_clk_en=1.
    - CYCLES increments each cycle and saturates at all-ones.
    - idle_ctr increments while busy_sync=0 and resets to 0 when busy_sync=1.
    - idle_ctr==IDLE_FILTER-1 with busy_sync=0 → DONE, done=1.
    - TIMEOUT≠0 and CYCLES==TIMEOUT-1 → DONE, timeout=1.
    - Completion and timeout in the same cycle: both flags set.
  - DONE (3): vx_clk_en=0, vx_reset=0, so core state is preserved.
    - Leaves to IDLE on the next cycle.
    - The done/timeout flags persist until cleared by W1C or by the next START.
- ABORT: from any state → IDLE next cycle. vx_reset=1 and vx_clk_en=0 immediately (registered next cycle). No flags are set.
- ABORT and START in the same write: ABORT wins.
- All outputs are registered.

Decomposition:
- Shared package vx_launch_pkg:
  - state enum (IDLE/RESET/RUN/DONE, 3 bits);
  - register offset constants (0x50–0x60);
  - STATUS bit positions.
- One sub-module, vx_apb_regs: APB decode, register storage, pslverr, prdata. The FSM, counters and synchronizer stay in the top.

Test Plan:
1. Reset release, then read MEM_BASE and STATUS → 0x0 and 0x0. Check vx_reset=1, vx_clk_en=0, irq=0.
2. Write MEM_BASE=0x8000_0000, then CTRL=1 with RESET_DELAY=8 → vx_reset high for 8 cycles with vx_clk_en=1. Hold busy high 100 cycles, then drop it → done=1 and irq=1 exactly IDLE_FILTER+2 cycles after busy falls (2 synchronizer cycles). CYCLES≈100+filter, exact value checked against the model.
3. TIMEOUT=50 with busy held high → enter DONE after exactly 50 RUN cycles. STATUS=0x6 (timeout|done) with state field 0 after return to IDLE, CYCLES=50, irq=1. W1C 0x6 → irq=0.
4. Busy glitch low for 2 cycles (<IDLE_FILTER=4) during RUN → no completion, idle_ctr restarts, state remains RUN.
5. ABORT mid-RUN → next cycle vx_reset=1, vx_clk_en=0, state IDLE, no irq. A write to MEM_BASE during RUN is ignored.
6. Read of offset 0x70 → pslverr=1 in the access phase. Assert reset_n low mid-RESET → all outputs at reset values without a clock edge.
